adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Parallel-ADC capture block; the receive-side counterpart of the DAC drive path.
- Generates the ADC sample clock AD_CLK_A from clk and samples the 12-bit AD_DATA_A bus.
- Discards the ADC pipeline-latency samples, waits for an optional level trigger, fills an internal buffer, then streams the buffer out over a valid/ready port.
- Sits beside the DAC drive block, fed from the 100 MHz PLL output on clk.

Parameters:
- DATA_W, 12, ADC sample width.
- DIV, 4, clk cycles per AD_CLK_A period; even, >=2.
- PIPE_LAT, 3, ADC pipeline latency in samples; discarded after each start.
- DEPTH, 256, capture buffer depth in samples; power of 2, >=4.
- PRETRIG, 16, samples kept from before the trigger; used only with ADC_PRETRIG_EN; must be <DEPTH.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- AD_CLK_A  out  1  ADC sample clock.
- AD_DATA_A  in  DATA_W  ADC output data, offset binary.
- AD_OTR_A  in  1  ADC over-range flag.
- start  in  1  one-cycle pulse; begins a capture.
- trig_en  in  1  1 = wait for trigger; 0 = capture immediately.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- rd_data  out  DATA_W  readout sample.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts.
- rd_last  out  1  marks the final sample (DEPTH-1).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last sample is accepted.
- ovr_flag  out  1  sticky: AD_OTR_A was high on any stored sample.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - AD_CLK_A=0, div_cnt=0, state=IDLE.
  - rd_valid, rd_last, busy, done, ovr_flag = 0; rd_data=0.
  - Buffer contents are don't-care.
  - Reset mid-capture or mid-readout aborts immediately; no done pulse.
- Clock divider:
  - div_cnt counts 0..DIV-1 and wraps; it is free-running in all states.
  - AD_CLK_A is registered: 0 while div_cnt<DIV/2, 1 otherwise. Period is DIV clk cycles, 50% duty.
  - sample_stb is asserted in the cycle where div_cnt==DIV/2-1. AD_DATA_A and AD_OTR_A are registered on that edge; samples arrive at clk/DIV.
- FSM states: IDLE, WARMUP, ARM, CAPTURE, READOUT.
  - IDLE: on start=1, clear ovr_flag and go to WARMUP.
  - WARMUP: count PIPE_LAT sample_stb, discarding each, then go to ARM.
  - ARM, trig_en=0: the first sample_stb goes to CAPTURE, and that sample is stored as index 0.
  - ARM, trig_en=1: trigger on a rising crossing only, i.e. prev<trig_level and cur>=trig_level, both unsigned. prev is the previous sample in ARM. The first ARM sample cannot trigger. The trigger sample is stored as index 0.
  - CAPTURE: store one sample per sample_stb; after DEPTH samples go to READOUT.
  - READOUT: present index 0..DEPTH-1 in order. A transfer occurs when rd_valid and rd_ready are both high.
    - rd_data and rd_valid hold stable while rd_ready=0.
    - Latency from one accept to the next valid is 1 clk at most (back-to-back throughput is required).
    - rd_last is high with index DEPTH-1. Accepting it pulses done, drops rd_valid next cycle, and returns to IDLE.
- start while busy is ignored.
- ovr_flag sets when a sample with OTR=1 is stored; it is cleared only by an accepted start or by reset.
- Buffer: inferred single-port or simple-dual-port RAM, DEPTH x DATA_W. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- trig_level and trig_en are sampled continuously in ARM; changing them mid-ARM takes effect on the next sample.

Optional Feature:
- Macro: ADC_PRETRIG_EN.
- Defined:
  - In ARM, every sample_stb writes into the buffer as a ring.
  - A trigger is accepted only after at least PRETRIG samples have been written in ARM.
  - On trigger, CAPTURE stores the trigger sample plus DEPTH-PRETRIG-1 further samples.
  - READOUT begins at (trigger write address - PRETRIG) mod DEPTH, so output index PRETRIG is the trigger sample.
  - With trig_en=0, behaviour is identical to the undefined case.
- Undefined: nothing is written in ARM, PRETRIG is unused, and the trigger sample is at index 0.

Test Plan:
- DIV=4, reset released, run 20 clk -> AD_CLK_A period 4 clk, high 2 / low 2; busy=0, rd_valid=0.
- DEPTH=16, PIPE_LAT=3, trig_en=0, AD_DATA_A = sample counter 0,1,2,... per AD_CLK_A -> first 3 samples discarded; readout 16 words 3..18 with rd_ready=1 every cycle, rd_last on 18, done pulse once.
- trig_en=1, trig_level=0x800, ramp input 0x7F0 step 4 -> first stored sample 0x800; repeat with a falling ramp -> no trigger, stays in ARM with busy=1.
- Random rd_ready toggling in READOUT -> no sample lost or duplicated, and rd_data is stable while stalled.
- AD_OTR_A=1 on one captured sample -> ovr_flag=1 after capture, remains 1 until the next start; rst_n=0 in CAPTURE -> all outputs return to reset values next cycle, no done pulse.
- ADC_PRETRIG_EN defined, DEPTH=16, PRETRIG=4, trigger at ramp value 0x800 step 4 -> readout index 0..3 = 0x7F0..0x7FC, index 4 = 0x800.

Source files
------------

// File: rtl/adc_capture.sv
// Parallel-ADC capture: divides clk into AD_CLK_A, drops pipeline-latency samples, optionally
// waits for a rising level crossing, fills a DEPTH buffer and streams it out. Option: ADC_PRETRIG_EN.
module adc_capture #(
    parameter int DATA_W   = 12,
    parameter int DIV      = 4,
    parameter int PIPE_LAT = 3,
    parameter int DEPTH    = 256,
    parameter int PRETRIG  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              AD_CLK_A,
    input  logic [DATA_W-1:0] AD_DATA_A,
    input  logic              AD_OTR_A,
    input  logic              start,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              ovr_flag,
    output logic [2:0]        dbg_state
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(PIPE_LAT + 2);

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF  = DCW'(DIV / 2);
    localparam logic [DCW-1:0] STB_CNT   = DCW'(DIV / 2 - 1);
    localparam logic [PW-1:0]  WARM_LAST = PW'(PIPE_LAT - 1);
    localparam logic [CW-1:0]  REM_FULL  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  REM_POST  = CW'(DEPTH - PRETRIG - 1);
    localparam logic [AW-1:0]  PRE_OFS   = AW'(PRETRIG);
    localparam logic [AW-1:0]  LAST_IDX  = AW'(DEPTH - 1);
`ifdef ADC_PRETRIG_EN
    localparam bit PRETRIG_ON = 1'b1;
`else
    localparam bit PRETRIG_ON = 1'b0;
`endif

    // Handshake: a word transfers on a clk edge where rd_valid and rd_ready are both high;
    // rd_data/rd_valid/rd_last only change after a transfer (or on entry to READOUT).
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARMUP  = 3'd1,
        S_ARM     = 3'd2,
        S_CAPTURE = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t              state_q;
    logic [DCW-1:0]      div_cnt_q, div_cnt_d;
    logic                ad_clk_q;
    logic [DATA_W-1:0]   samp_q, prev_q;
    logic                otr_q, samp_vld_q, prev_vld_q;
    logic [PW-1:0]       warm_cnt_q;
    logic [CW-1:0]       cap_rem_q, rem_init;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q, out_cnt_q, out_idx_d, base_addr, rd_addr;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q, rd_last_q, done_q, ovr_q;
    logic                sample_stb, crossing, pre_ok, ring_we, arm_smp, cap_smp;
    logic                fire, use_pre, mem_we, enter_ro, accept, ld;
    logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef ADC_PRETRIG_EN
    logic [CW-1:0]       arm_cnt_q;
`endif

    always_comb begin
        div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        sample_stb = (div_cnt_q == STB_CNT);
        crossing   = prev_vld_q && (prev_q < trig_level) && (samp_q >= trig_level);
        arm_smp    = (state_q == S_ARM) && samp_vld_q;
        cap_smp    = (state_q == S_CAPTURE) && samp_vld_q;
`ifdef ADC_PRETRIG_EN
        pre_ok     = (arm_cnt_q >= CW'(PRETRIG));
        ring_we    = arm_smp;
`else
        pre_ok     = 1'b1;
        ring_we    = 1'b0;
`endif
        fire       = arm_smp && (!trig_en || (crossing && pre_ok));
        use_pre    = PRETRIG_ON && trig_en;
        rem_init   = use_pre ? REM_POST : REM_FULL;
        base_addr  = use_pre ? wr_ptr_q - PRE_OFS : wr_ptr_q;
        mem_we     = fire || cap_smp || ring_we;
        enter_ro   = (fire && (rem_init == '0)) || (cap_smp && (cap_rem_q == CW'(1)));
        accept     = (state_q == S_READOUT) && rd_valid_q && rd_ready;
        ld         = enter_ro || (accept && !rd_last_q);
        out_idx_d  = enter_ro ? '0 : out_cnt_q + 1'b1;
        case (state_q)
            S_ARM:     rd_addr = base_addr;
            S_READOUT: rd_addr = rd_ptr_q + 1'b1;
            default:   rd_addr = rd_ptr_q;
        endcase
    end

    // Free-running divider; input bus is registered on the edge where AD_CLK_A rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            ad_clk_q   <= 1'b0;
            samp_q     <= '0;
            otr_q      <= 1'b0;
            samp_vld_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            ad_clk_q   <= (div_cnt_d >= DIV_HALF);
            samp_vld_q <= sample_stb;
            if (sample_stb) begin
                samp_q <= AD_DATA_A;
                otr_q  <= AD_OTR_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= samp_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rd_data_q <= '0;
        else if (ld) rd_data_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            warm_cnt_q <= '0;
            cap_rem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef ADC_PRETRIG_EN
            arm_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (mem_we) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (mem_we && otr_q) ovr_q <= 1'b1;
            case (state_q)
                S_IDLE: if (start) begin
                    ovr_q      <= 1'b0;
                    wr_ptr_q   <= '0;
                    prev_vld_q <= 1'b0;
                    warm_cnt_q <= '0;
`ifdef ADC_PRETRIG_EN
                    arm_cnt_q  <= '0;
`endif
                    state_q    <= (PIPE_LAT == 0) ? S_ARM : S_WARMUP;
                end
                S_WARMUP: if (samp_vld_q) begin
                    warm_cnt_q <= warm_cnt_q + 1'b1;
                    if (warm_cnt_q == WARM_LAST) state_q <= S_ARM;
                end
                S_ARM: if (samp_vld_q) begin
                    prev_q     <= samp_q;
                    prev_vld_q <= 1'b1;
`ifdef ADC_PRETRIG_EN
                    if (arm_cnt_q < CW'(PRETRIG)) arm_cnt_q <= arm_cnt_q + 1'b1;
`endif
                    if (fire) begin
                        rd_ptr_q  <= base_addr;
                        cap_rem_q <= rem_init;
                        state_q   <= (rem_init == '0) ? S_READOUT : S_CAPTURE;
                    end
                end
                S_CAPTURE: if (samp_vld_q) begin
                    cap_rem_q <= cap_rem_q - 1'b1;
                    if (cap_rem_q == CW'(1)) state_q <= S_READOUT;
                end
                S_READOUT: if (accept && rd_last_q) begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_ro) rd_valid_q <= 1'b1;
            if (ld) begin
                rd_ptr_q  <= rd_addr;
                out_cnt_q <= out_idx_d;
                rd_last_q <= (out_idx_d == LAST_IDX);
            end
        end
    end

    assign AD_CLK_A  = ad_clk_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign ovr_flag  = ovr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: an ADC model clocked by AD_CLK_A feeds ramps, expected
// readout words are queued at start time and popped as the DUT transfers them.
module tb_adc_capture;

    localparam int DATA_W   = 12;
    localparam int DIV      = 4;
    localparam int PIPE_LAT = 3;
    localparam int DEPTH    = 16;
    localparam int PRETRIG  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              AD_CLK_A;
    logic [DATA_W-1:0] AD_DATA_A;
    logic              AD_OTR_A;
    logic              start = 1'b0;
    logic              trig_en = 1'b0;
    logic [DATA_W-1:0] trig_level = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic              rd_last, busy, done, ovr_flag;
    logic [2:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int adc_cnt = 0;
    int done_cnt = 0;
    int gen_base = 0, gen_step = 0, gen_off = 0, otr_at = -1000;
    logic [DATA_W-1:0] exp_q[$];

    adc_capture #(.DATA_W(DATA_W), .DIV(DIV), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
        .clk(clk), .rst_n(rst_n), .AD_CLK_A(AD_CLK_A), .AD_DATA_A(AD_DATA_A), .AD_OTR_A(AD_OTR_A),
        .start(start), .trig_en(trig_en), .trig_level(trig_level), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done),
        .ovr_flag(ovr_flag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ADC model: new output word shortly after each falling AD_CLK_A edge
    always @(negedge AD_CLK_A) begin
        #1;
        adc_cnt = adc_cnt + 1;
        AD_DATA_A = DATA_W'(gen_base + gen_step * (adc_cnt - gen_off));
        AD_OTR_A = ((adc_cnt - gen_off) == otr_at);
    end

    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start just after an AD_CLK_A rise so the ramp's index 0 is the first counted sample
    task automatic issue_start(input int base, input int step, input int otr);
        int b = 100;
        logic p;
        p = AD_CLK_A;
        while (b > 0) begin
            @(posedge clk); #1;
            b--;
            if (AD_CLK_A && !p) break;
            p = AD_CLK_A;
        end
        if (b == 0) check("adclk_rise_timeout", 32'(AD_CLK_A), 32'd1);
        gen_base = base;
        gen_step = step;
        otr_at   = otr;
        gen_off  = adc_cnt + 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_readout(input int n, input bit rand_ready);
        int got = 0;
        int budget = 3000;
        int done_before;
        bit held_pending = 1'b0;
        logic [DATA_W-1:0] held = '0;
        logic [DATA_W-1:0] exp;
        done_before = done_cnt;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (held_pending) begin
                check("stall_valid", 32'(rd_valid), 32'd1);
                check("stall_data", 32'(rd_data), 32'(held));
            end
            rd_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            held_pending = 1'b0;
            if (rd_valid) begin
                if (rd_ready) begin
                    exp = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(exp));
                    check("rd_last", 32'(rd_last), 32'(got == n - 1));
                    got++;
                end else begin
                    held_pending = 1'b1;
                    held = rd_data;
                end
            end
        end
        if (got < n) check("readout_timeout", 32'(got), 32'(n));
        @(negedge clk);
        rd_ready = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("valid_drop", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done_cnt - done_before), 32'd1);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [19:0] clk_obs, clk_exp;
        int dc;

        // Reset values and divider waveform
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_misc", 32'({rd_last, done, ovr_flag}), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            clk_obs[k] = AD_CLK_A;
            clk_exp[k] = ((k % DIV) >= DIV / 2);
        end
        check("adclk_pattern", 32'(clk_obs), 32'(clk_exp));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(rd_valid), 32'd0);

        // Immediate capture of a counter; a second start while busy is ignored
        trig_en = 1'b0;
        for (int i = PIPE_LAT; i < PIPE_LAT + DEPTH; i++) exp_q.push_back(DATA_W'(i));
        issue_start(0, 1, -1000);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_readout(DEPTH, 1'b0);
        check("ovr_clean", 32'(ovr_flag), 32'd0);

        // Rising-crossing trigger with random back-pressure and one over-range sample
        trig_en = 1'b1;
        trig_level = 12'h800;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ADC_PRETRIG_EN
            exp_q.push_back(DATA_W'(12'h7F0 + 4 * i));
`else
            exp_q.push_back(DATA_W'(12'h800 + 4 * i));
`endif
        end
        issue_start(12'h7E0, 4, 12);
        run_readout(DEPTH, 1'b1);
        check("ovr_set", 32'(ovr_flag), 32'd1);
        check("sb_empty_trig", 32'(exp_q.size()), 32'd0);

        // Falling ramp never crosses upward: stays armed; start cleared ovr_flag
        issue_start(12'h810, -4, -1000);
        @(posedge clk); #1;
        check("ovr_cleared", 32'(ovr_flag), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_state", 32'(dbg_state), 32'd2);
        check("arm_no_valid", 32'(rd_valid), 32'd0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("arm_rst_busy", 32'(busy), 32'd0);
        check("arm_rst_clk", 32'(AD_CLK_A), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset during CAPTURE aborts without a done pulse
        trig_en = 1'b0;
        issue_start(0, 1, 5);
        repeat (40) @(posedge clk);
        #1;
        check("cap_state", 32'(dbg_state), 32'd3);
        check("cap_ovr", 32'(ovr_flag), 32'd1);
        dc = done_cnt;
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("crst_busy", 32'(busy), 32'd0);
        check("crst_outs", 32'({rd_valid, rd_last, done, ovr_flag, AD_CLK_A}), 32'd0);
        check("crst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("crst_no_done", 32'(done_cnt - dc), 32'd0);
        check("crst_idle", 32'({busy, rd_valid}), 32'd0);
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
